// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access stage.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Encodings with no defined load/store size.
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads,
// and misalignment/illegal-size detection.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        fault_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        fault_o = f3_illegal(funct3_i);
        case (funct3_i[1:0])
            2'b01:   if (addr_lo_i[0]) fault_o = 1'b1;
            2'b10:   if (addr_lo_i != 2'b00) fault_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        be_o    = 4'hF;
        wdata_o = store_data_i;
        if (is_store_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{store_data_i[7:0]}};
                end
                2'b01: begin
                    be_o    = 4'b0011 << addr_lo_i;
                    wdata_o = {2{store_data_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        unique case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data_o = rdata_i;
            F3_BU:   load_data_o = {24'h0, byte_sel};
            F3_HU:   load_data_o = {16'h0, half_sel};
            default: load_data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues data-memory requests, holds the slot across wait states,
// and registers the MEM/WB outputs.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        valid_m,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,

    output logic        StallM,
    output logic        valid_w,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUResultW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic        FaultW
);

    state_e      state_q, state_d;

    logic [31:0] addr_q, wdata_q, pc_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic        we_q;

    logic        busy;
    logic        mem_op;
    logic        fault;
    logic        complete;

    logic [31:0] a_addr, a_wdata, a_pc;
    logic [4:0]  a_rd;
    logic [2:0]  a_f3;
    logic        a_we;

    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load;
    logic        al_fault;

    logic        valid_w_q, valid_w_d;
    logic        fault_w_q, fault_w_d;
    logic [31:0] rdata_w_q, rdata_w_d;
    logic [31:0] alu_w_q,   alu_w_d;
    logic [4:0]  rd_w_q,    rd_w_d;
    logic [31:0] pc_w_q,    pc_w_d;

    assign busy   = (state_q == BUSY);
    assign mem_op = valid_m & (MemReadM | MemWriteM);

    // A single aligner serves both phases: live slot in IDLE, held copy in BUSY.
    always_comb begin
        a_addr  = busy ? addr_q  : ALUResultM;
        a_wdata = busy ? wdata_q : WriteDataM;
        a_pc    = busy ? pc_q    : PCPlus4M;
        a_rd    = busy ? rd_q    : RdM;
        a_f3    = busy ? f3_q    : Funct3M;
        a_we    = busy ? we_q    : MemWriteM;
    end

    load_store_align u_align (
        .addr_lo_i    (a_addr[1:0]),
        .funct3_i     (a_f3),
        .is_store_i   (a_we),
        .store_data_i (a_wdata),
        .rdata_i      (dmem_rdata),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .load_data_o  (al_load),
        .fault_o      (al_fault)
    );

    assign fault = !busy & mem_op & al_fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (dmem_req && !dmem_ready) state_d = BUSY;
            BUSY: if (dmem_ready)              state_d = IDLE;
        endcase
    end

    always_comb begin
        dmem_req = 1'b0;
        if (reset) dmem_req = busy | (mem_op & !al_fault);
        dmem_we    = dmem_req & a_we;
        dmem_addr  = dmem_req ? {a_addr[31:2], 2'b00} : '0;
        dmem_wdata = dmem_req ? al_wdata : '0;
        dmem_be    = dmem_req ? al_be : '0;
        StallM     = dmem_req & !dmem_ready;
        complete   = dmem_req & dmem_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
        end else if (!busy && StallM) begin
            addr_q  <= ALUResultM;
            wdata_q <= WriteDataM;
            pc_q    <= PCPlus4M;
            rd_q    <= RdM;
            f3_q    <= Funct3M;
            we_q    <= MemWriteM;
        end
    end

    always_comb begin
        valid_w_d = 1'b0;
        fault_w_d = 1'b0;
        rdata_w_d = '0;
        alu_w_d   = '0;
        rd_w_d    = '0;
        pc_w_d    = '0;
        if (StallM) begin
            valid_w_d = 1'b0;
        end else if (complete) begin
            valid_w_d = 1'b1;
            rdata_w_d = a_we ? '0 : al_load;
            alu_w_d   = a_addr;
            rd_w_d    = a_rd;
            pc_w_d    = a_pc;
        end else if (fault) begin
            valid_w_d = 1'b1;
            fault_w_d = 1'b1;
            alu_w_d   = ALUResultM;
            pc_w_d    = PCPlus4M;
        end else if (valid_m) begin
            valid_w_d = 1'b1;
            alu_w_d   = ALUResultM;
            rd_w_d    = RdM;
            pc_w_d    = PCPlus4M;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_w_q <= 1'b0;
            fault_w_q <= 1'b0;
            rdata_w_q <= '0;
            alu_w_q   <= '0;
            rd_w_q    <= '0;
            pc_w_q    <= '0;
        end else begin
            valid_w_q <= valid_w_d;
            fault_w_q <= fault_w_d;
            rdata_w_q <= rdata_w_d;
            alu_w_q   <= alu_w_d;
            rd_w_q    <= rd_w_d;
            pc_w_q    <= pc_w_d;
        end
    end

    assign valid_w    = valid_w_q;
    assign FaultW     = fault_w_q;
    assign ReadDataW  = rdata_w_q;
    assign ALUResultW = alu_w_q;
    assign RdW        = rd_w_q;
    assign PCPlus4W   = pc_w_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a slot-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_m = 1'b0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic [4:0]  RdM = '0;
    logic [31:0] PCPlus4M = '0;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [2:0]  Funct3M = '0;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;

    logic        dmem_req, dmem_we, StallM, valid_w, FaultW;
    logic [31:0] dmem_addr, dmem_wdata, ReadDataW, ALUResultW, PCPlus4W;
    logic [3:0]  dmem_be;
    logic [4:0]  RdW;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk        (clk),
        .reset      (reset),
        .valid_m    (valid_m),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdM        (RdM),
        .PCPlus4M   (PCPlus4M),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .StallM     (StallM),
        .valid_w    (valid_w),
        .ReadDataW  (ReadDataW),
        .ALUResultW (ALUResultW),
        .RdW        (RdW),
        .PCPlus4W   (PCPlus4W),
        .FaultW     (FaultW)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
    } slot_t;

    typedef struct packed {
        logic        v;
        logic        f;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] pc;
    } wb_t;

    slot_t held;
    bit    held_v = 1'b0;
    wb_t   exp_w = '0;

    function automatic slot_t cur_slot();
        slot_t s;
        s.v = valid_m; s.addr = ALUResultM; s.data = WriteDataM; s.rd = RdM;
        s.pc = PCPlus4M; s.mr = MemReadM; s.mw = MemWriteM; s.f3 = Funct3M;
        return s;
    endfunction

    function automatic bit is_mem(input slot_t s);
        return s.v && (s.mr || s.mw);
    endfunction

    function automatic bit illegal(input slot_t s);
        int unsigned sz, a;
        sz = 32'(s.f3) % 4;
        a  = s.addr % 4;
        return (s.f3 == 3'd3) || (s.f3 == 3'd6) || (s.f3 == 3'd7) ||
               (sz == 1 && a % 2 != 0) || (sz == 2 && a != 0);
    endfunction

    function automatic logic [3:0] exp_be(input slot_t s);
        int unsigned a;
        a = s.addr % 4;
        if (!s.mw) return 4'hF;
        case (32'(s.f3) % 4)
            0:       return 4'(1 << a);
            1:       return 4'(3 << a);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input slot_t s);
        case (32'(s.f3) % 4)
            0:       return (s.data % 256) * 32'h01010101;
            1:       return (s.data % 65536) * 32'h00010001;
            default: return s.data;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input slot_t s, input logic [31:0] word);
        logic [31:0] sh, v;
        sh = word >> (8 * (s.addr % 4));
        case (s.f3)
            3'd0: begin v = sh & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
            3'd1: begin v = sh & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
            3'd2: v = word;
            3'd4: v = sh & 32'hFF;
            3'd5: v = sh & 32'hFFFF;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin : model
        slot_t s;
        bit flt, req;
        wb_t w;
        if (!reset) begin
            held_v <= 1'b0;
            exp_w  <= '0;
        end else begin
            s   = held_v ? held : cur_slot();
            flt = !held_v && is_mem(s) && illegal(s);
            req = held_v || (is_mem(s) && !flt);
            w   = '0;
            if (req && dmem_ready) begin
                w.v = 1'b1; w.rdata = s.mw ? 32'h0 : exp_load(s, dmem_rdata);
                w.alu = s.addr; w.rd = s.rd; w.pc = s.pc;
                held_v <= 1'b0;
            end else if (req) begin
                held   <= s;
                held_v <= 1'b1;
            end else if (flt) begin
                w.v = 1'b1; w.f = 1'b1;
            end else if (s.v) begin
                w.v = 1'b1; w.alu = s.addr; w.rd = s.rd; w.pc = s.pc;
            end
            exp_w <= w;
        end
    end

    always @(negedge clk) begin : compare
        slot_t s;
        bit req;
        s   = held_v ? held : cur_slot();
        req = reset && (held_v || (is_mem(s) && !illegal(s)));
        chk("dmem_req", 32'(dmem_req), 32'(req));
        chk("StallM", 32'(StallM), 32'(req && !dmem_ready));
        if (req) begin
            chk("dmem_addr", dmem_addr, s.addr & 32'hFFFFFFFC);
            chk("dmem_we", 32'(dmem_we), 32'(s.mw));
            chk("dmem_be", 32'(dmem_be), 32'(exp_be(s)));
            if (s.mw) chk("dmem_wdata", dmem_wdata, exp_wdata(s));
        end
        chk("valid_w", 32'(valid_w), 32'(exp_w.v));
        chk("FaultW", 32'(FaultW), 32'(exp_w.f));
        if (exp_w.v) begin
            chk("RdW", 32'(RdW), 32'(exp_w.rd));
            if (!exp_w.f) begin
                chk("ReadDataW", ReadDataW, exp_w.rdata);
                chk("ALUResultW", ALUResultW, exp_w.alu);
                chk("PCPlus4W", PCPlus4W, exp_w.pc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic [31:0] pc,
                         input logic mr, input logic mw, input logic [2:0] f3);
        valid_m = v; ALUResultM = addr; WriteDataM = data; RdM = rd;
        PCPlus4M = pc; MemReadM = mr; MemWriteM = mw; Funct3M = f3;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    // Issues one memory slot, answers after 'waits' wait cycles, returns the
    // number of stalled cycles seen and whether dmem_addr held steady.
    task automatic run_mem(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                           input logic mr, input logic mw, input logic [2:0] f3,
                           input logic [31:0] rdata, input int unsigned waits,
                           output int unsigned stalls, output logic [31:0] first_addr,
                           output bit addr_stable);
        drive(1'b1, addr, data, rd, addr + 32'h1000, mr, mw, f3);
        dmem_rdata  = rdata;
        stalls      = 0;
        addr_stable = 1'b1;
        first_addr  = '0;
        for (int unsigned i = 0; i <= waits; i++) begin
            dmem_ready = (i == waits);
            #1;
            if (i == 0) first_addr = dmem_addr;
            else if (dmem_addr !== first_addr) addr_stable = 1'b0;
            if (StallM) stalls++;
            if (i > 0) chk("bubble_valid_w", 32'(valid_w), 32'h0);
            step();
        end
        idle();
        dmem_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int unsigned waits;
        logic [31:0] exp_rdw;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int unsigned stalls;
        logic [31:0] a0;
        bit stable;

        vecs[0] = '{32'h0000_0002, 32'h0, 1'b1, 1'b0, F3_H,  32'h8001_7FFF, 1, 32'hFFFF_8001, 1'b0};
        vecs[1] = '{32'h0000_0101, 32'h0, 1'b1, 1'b0, F3_BU, 32'h0000_AB00, 0, 32'h0000_00AB, 1'b0};
        vecs[2] = '{32'h0000_0003, 32'h77, 1'b0, 1'b1, F3_B, 32'h0,         1, 32'h0,         1'b0};
        vecs[3] = '{32'h0000_0004, 32'h0, 1'b1, 1'b0, F3_W,  32'hCAFE_F00D, 3, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{32'h0000_0003, 32'h0, 1'b1, 1'b0, F3_H,  32'h0,         0, 32'h0,         1'b1};
        vecs[5] = '{32'h0000_0000, 32'h5, 1'b0, 1'b1, 3'b011, 32'h0,        0, 32'h0,         1'b1};
        vecs[6] = '{32'h0000_0000, 32'h0, 1'b1, 1'b0, F3_B,  32'h0000_007F, 0, 32'h0000_007F, 1'b0};

        #1 reset = 1'b0;
        drive(1'b1, 32'h200, 32'h0, 5'd1, 32'h204, 1'b1, 1'b0, F3_W);
        step();
        chk("reset_dmem_req", 32'(dmem_req), 32'h0);
        chk("reset_StallM", 32'(StallM), 32'h0);
        chk("reset_valid_w", 32'(valid_w), 32'h0);
        chk("reset_ReadDataW", ReadDataW, 32'h0);
        chk("reset_RdW", 32'(RdW), 32'h0);
        idle();
        step();
        reset = 1'b1;
        step();

        // SW, zero wait
        drive(1'b1, 32'h100, 32'hDEADBEEF, 5'd3, 32'h104, 1'b0, 1'b1, F3_W);
        dmem_ready = 1'b1;
        #1;
        chk("sw_be", 32'(dmem_be), 32'hF);
        chk("sw_stall", 32'(StallM), 32'h0);
        chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        step();
        chk("sw_valid_w", 32'(valid_w), 32'h1);
        idle();
        dmem_ready = 1'b0;
        step();

        // LB at byte 3 with two wait cycles
        run_mem(32'h103, 32'h0, 5'd7, 1'b1, 1'b0, F3_B, 32'h8012_3456, 2, stalls, a0, stable);
        chk("lb_stall_cycles", stalls, 32'd2);
        chk("lb_addr", a0, 32'h100);
        chk("lb_addr_stable", 32'(stable), 32'h1);
        chk("lb_valid_w", 32'(valid_w), 32'h1);
        chk("lb_ReadDataW", ReadDataW, 32'hFFFF_FF80);
        chk("lb_RdW", 32'(RdW), 32'd7);

        // LHU upper half
        run_mem(32'h102, 32'h0, 5'd8, 1'b1, 1'b0, F3_HU, 32'hBEEF_0000, 0, stalls, a0, stable);
        chk("lhu_ReadDataW", ReadDataW, 32'h0000_BEEF);

        // Misaligned LW
        drive(1'b1, 32'h101, 32'h0, 5'd9, 32'h108, 1'b1, 1'b0, F3_W);
        #1;
        chk("lw_mis_req", 32'(dmem_req), 32'h0);
        chk("lw_mis_stall", 32'(StallM), 32'h0);
        step();
        chk("lw_mis_FaultW", 32'(FaultW), 32'h1);
        chk("lw_mis_RdW", 32'(RdW), 32'h0);
        chk("lw_mis_valid_w", 32'(valid_w), 32'h1);
        idle();
        step();

        // Reset while BUSY, then a stray ready
        drive(1'b1, 32'h300, 32'h0, 5'd4, 32'h304, 1'b1, 1'b0, F3_W);
        step();
        chk("busy_stall", 32'(StallM), 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("rst_busy_req", 32'(dmem_req), 32'h0);
        chk("rst_busy_stall", 32'(StallM), 32'h0);
        chk("rst_busy_valid_w", 32'(valid_w), 32'h0);
        idle();
        step();
        reset = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk("late_ready_req", 32'(dmem_req), 32'h0);
        step();
        chk("late_ready_valid_w", 32'(valid_w), 32'h0);
        dmem_ready = 1'b0;
        step();

        // ALU op, bubble, SH
        drive(1'b1, 32'h55, 32'h0, 5'd10, 32'h400, 1'b0, 1'b0, 3'b000);
        step();
        chk("alu_valid_w", 32'(valid_w), 32'h1);
        chk("alu_ReadDataW", ReadDataW, 32'h0);
        chk("alu_ALUResultW", ALUResultW, 32'h55);
        idle();
        step();
        chk("bubble_valid_w0", 32'(valid_w), 32'h0);
        drive(1'b1, 32'h2, 32'h1234, 5'd11, 32'h408, 1'b0, 1'b1, F3_H);
        dmem_ready = 1'b1;
        #1;
        chk("sh_be", 32'(dmem_be), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'h1234_1234);
        step();
        chk("sh_valid_w", 32'(valid_w), 32'h1);
        idle();
        dmem_ready = 1'b0;
        step();

        foreach (vecs[k]) begin
            run_mem(vecs[k].addr, vecs[k].data, 5'd12, vecs[k].mr, vecs[k].mw, vecs[k].f3,
                    vecs[k].rdata, vecs[k].waits, stalls, a0, stable);
            chk($sformatf("vec%0d_valid_w", k), 32'(valid_w), 32'h1);
            chk($sformatf("vec%0d_FaultW", k), 32'(FaultW), 32'(vecs[k].exp_fault));
            chk($sformatf("vec%0d_ReadDataW", k), ReadDataW, vecs[k].exp_rdw);
            chk($sformatf("vec%0d_stalls", k), stalls,
                vecs[k].exp_fault ? 32'd0 : 32'(vecs[k].waits));
            step();
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
